// File: rtl/icache_linebuf.sv
// IF-stage line buffer: ENTRIES fully-associative lines refilled over valid/ready.
// Define ICACHE_LINEBUF_PREFETCH_EN for next-line prefetch after demand fills.
module icache_linebuf #(
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned ENTRIES     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter logic [31:0] REGION_SIZE = 32'h00040000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                addr,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       inval,
  output logic [31:0]                inst,
  output logic                       stall_req,
  output logic                       error,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_resp_valid,
  input  logic [LINE_WORDS*32-1:0]   mem_resp_data
);
  localparam int unsigned OFF = $clog2(LINE_WORDS * 4);
  localparam int unsigned WW  = $clog2(LINE_WORDS);
  localparam int unsigned TW  = 32 - OFF;
  localparam int unsigned PW  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + {1'b0, REGION_SIZE};

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                   state, nxt;
  logic [TW-1:0]            tag;
  logic [WW-1:0]            wsel;
  logic [ENTRIES-1:0]       valid;
  logic [TW-1:0]            tags  [ENTRIES];
  logic [LINE_WORDS*32-1:0] lines [ENTRIES];
  logic [PW-1:0]            rep_ptr;
  logic [31:0]              req_addr;
  logic [31:0]              load_addr;
  logic [LINE_WORDS*32-1:0] hit_line;
  logic [31:0]              hit_word;
  logic                     hit, miss, fill, load;

  assign tag  = addr[31:OFF];
  assign wsel = addr[OFF-1:2];

  assign error = (|addr[1:0]) | (addr < BASE_ADDR) |
                 ({1'b0, addr} >= LIMIT);

  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tags[i] == tag) begin
        hit      = 1'b1;
        hit_line = lines[i];
      end
    end
  end

  assign hit_word  = hit_line[32*wsel +: 32];
  assign miss      = !error && !hit;
  assign stall_req = rst && miss;

  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = req_addr;
  // inval in the response cycle drops the line
  assign fill = (state == WAIT) && mem_resp_valid && !inval;

`ifdef ICACHE_LINEBUF_PREFETCH_EN
  localparam logic [32:0] LB = 33'(LINE_WORDS * 4);

  logic        pf_pend, pf_cur, pf_ok, pf_have, pf_load;
  logic [32:0] pf_next;

  always_comb begin
    pf_next = {1'b0, req_addr} + LB;
    pf_have = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tags[i] == pf_next[31:OFF]) pf_have = 1'b1;
    end
    pf_ok = (ENTRIES > 1) && pf_pend && !pf_have &&
            (pf_next >= {1'b0, BASE_ADDR}) && (pf_next < LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pf_pend <= 1'b0;
      pf_cur  <= 1'b0;
    end else begin
      if (inval || load)           pf_pend <= 1'b0;
      else if (fill && !pf_cur)    pf_pend <= 1'b1;
      else if (state == IDLE && !miss) pf_pend <= 1'b0;
      if (load) pf_cur <= pf_load;
    end
  end
`endif

  always_comb begin
    nxt       = state;
    load      = 1'b0;
    load_addr = {tag, {OFF{1'b0}}};
`ifdef ICACHE_LINEBUF_PREFETCH_EN
    pf_load   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (miss && !flush) begin
          nxt  = REQ;
          load = 1'b1;
        end
`ifdef ICACHE_LINEBUF_PREFETCH_EN
        else if (!miss && pf_ok) begin
          nxt       = REQ;
          load      = 1'b1;
          pf_load   = 1'b1;
          load_addr = pf_next[31:0];
        end
`endif
      end
      REQ:     if (mem_req_ready) nxt = WAIT;
      WAIT:    if (inval || mem_resp_valid) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req_addr <= '0;
      valid    <= '0;
      rep_ptr  <= '0;
    end else begin
      state <= nxt;
      if (load) req_addr <= load_addr;
      if (inval)     valid <= '0;
      else if (fill) valid[rep_ptr] <= 1'b1;
      if (fill) rep_ptr <= (ENTRIES > 1) ? rep_ptr + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      lines[rep_ptr] <= mem_resp_data;
      tags[rep_ptr]  <= req_addr[31:OFF];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst <= '0;
    end else if (flush) begin
      inst <= '0;
    end else if (!stall) begin
      if (error)    inst <= '0;
      else if (hit) inst <= hit_word;
    end
  end
endmodule

// File: tb/tb_icache_linebuf.sv
// Bench for icache_linebuf: line-list reference model, ROM-backed responder,
// scoreboard queue drained by a negedge monitor.
module tb_icache_linebuf;
  localparam int LW = 4;
  localparam int NE = 2;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam logic [31:0] RSZ  = 32'h00040000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [31:0]       addr = '0;
  logic              stall = 1'b0, flush = 1'b0, inval = 1'b0;
  logic [31:0]       inst;
  logic              stall_req, error, mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [31:0]       mem_req_addr;
  logic              mem_resp_valid = 1'b0;
  logic [LW*32-1:0]  mem_resp_data = '0;

  icache_linebuf #(
    .LINE_WORDS(LW), .ENTRIES(NE),
    .BASE_ADDR(BASE), .REGION_SIZE(RSZ)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr),
    .stall(stall), .flush(flush), .inval(inval),
    .inst(inst), .stall_req(stall_req), .error(error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        sreq;
    logic        rv;
    logic [31:0] ra;
    logic [31:0] inst;
  } exp_t;

  typedef enum int {O_NONE, O_REQ, O_ACC} ost_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  ost_t        ost = O_NONE;
  logic [31:0] o_addr = '0;
  int          lat_cnt = 0;
  int          lat = 3;
  int          rdy_pct = 100;
  bit          spur = 1'b0;
  bit          inv_on_rsp = 1'b0;
  logic [31:0] m_lines[$];
  logic [31:0] m_inst = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a[31:4] == 28'h8000000) begin
      case (a[3:2])
        2'd0:    return 32'h00000013;
        2'd1:    return 32'h00000093;
        2'd2:    return 32'h00100113;
        default: return 32'h0000006F;
      endcase
    end
    return (a ^ 32'h5BD1E995) * 32'h01000193 + 32'h13;
  endfunction

  function automatic logic [LW*32-1:0] rom_line(input logic [31:0] la);
    logic [LW*32-1:0] l;
    l = '0;
    for (int i = 0; i < LW; i++) l[32*i +: 32] = rom(la + 32'(4*i));
    return l;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:4], 4'h0};
  endfunction

  function automatic bit bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE) ||
           (64'(a) >= 64'(BASE) + 64'(RSZ));
  endfunction

  function automatic bit held(input logic [31:0] la);
    foreach (m_lines[i]) if (m_lines[i] == la) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cycle(input logic [31:0] a, input bit st,
                       input bit fl, input bit iv);
    exp_t             e;
    bit               rdy, rsp, err_e, hit_e;
    logic [LW*32-1:0] rd;
    rdy = (ost == O_REQ) ? ($urandom_range(99) < rdy_pct)
                         : ($urandom_range(1) == 1);
    rsp = 1'b0;
    rd  = {$urandom, $urandom, $urandom, $urandom};
    if (ost == O_ACC && lat_cnt >= lat) begin
      rsp = 1'b1;
      rd  = rom_line(o_addr);
      if (inv_on_rsp) begin
        iv = 1'b1;
        inv_on_rsp = 1'b0;
      end
    end else if (ost != O_ACC && spur && $urandom_range(9) == 0) begin
      rsp = 1'b1;
    end
    addr = a; stall = st; flush = fl; inval = iv;
    mem_req_ready = rdy; mem_resp_valid = rsp; mem_resp_data = rd;
    err_e  = bad(a);
    hit_e  = !err_e && held(line_of(a));
    e.err  = err_e;
    e.sreq = !err_e && !hit_e;
    e.rv   = (ost == O_REQ);
    e.ra   = o_addr;
    e.inst = m_inst;
    sbq.push_back(e);
    @(posedge clk);
    if (fl) m_inst = '0;
    else if (!st) begin
      if (err_e)      m_inst = '0;
      else if (hit_e) m_inst = rom(a);
    end
    case (ost)
      O_NONE: if (!err_e && !hit_e && !fl) begin
        ost = O_REQ;
        o_addr = line_of(a);
      end
      O_REQ: if (rdy) begin
        ost = O_ACC;
        lat_cnt = 0;
      end
      O_ACC: begin
        if (iv) ost = O_NONE;
        else if (rsp) begin
          m_lines.push_back(o_addr);
          if (m_lines.size() > NE) void'(m_lines.pop_front());
          ost = O_NONE;
        end else lat_cnt++;
      end
      default: ;
    endcase
    if (iv) m_lines.delete();
    #1;
  endtask

  task automatic fill_line(input logic [31:0] a);
    int n;
    n = 0;
    while (!held(line_of(a)) && n < 64) begin
      cycle(a, 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!held(line_of(a))) begin
      n_fail++;
      $display("FAIL fill_timeout: line %h not filled in 64 cycles", a);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned k;
    k = $urandom_range(99);
    if (k < 8) begin
      case ($urandom_range(4))
        0:       return 32'h80040000;
        1:       return 32'h7FFFFFFC;
        2:       return 32'h80000012;
        3:       return 32'hFFFFFFFC;
        default: return 32'h8003FFF1;
      endcase
    end
    if (k < 18) return 32'h8003FFF0 + 32'(4 * $urandom_range(3));
    return BASE + 32'(16 * $urandom_range(4)) + 32'(4 * $urandom_range(3));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("error", {31'b0, error}, {31'b0, e.err});
        chk("stall_req", {31'b0, stall_req}, {31'b0, e.sreq});
        chk("mem_req_valid", {31'b0, mem_req_valid}, {31'b0, e.rv});
        if (e.rv) chk("mem_req_addr", mem_req_addr, e.ra);
        chk("inst", inst, e.inst);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] pc;
    addr = BASE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inst", inst, 32'h0);
    chk("rst_stall_req", {31'b0, stall_req}, 32'h0);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    lat = 3; rdy_pct = 100;
    fill_line(32'h80000008);
    cycle(32'h80000008, 1'b0, 1'b0, 1'b0);
    chk("cold_inst", inst, 32'h00100113);

    for (int i = 0; i < 4; i++) cycle(BASE + 32'(4*i), 1'b0, 1'b0, 1'b0);
    chk("seq_last_inst", inst, 32'h0000006F);

    cycle(32'h80040000, 1'b0, 1'b0, 1'b0);
    chk("err_top_inst", inst, 32'h0);
    cycle(32'h80000004, 1'b0, 1'b0, 1'b0);
    cycle(32'h80000002, 1'b0, 1'b0, 1'b0);
    chk("err_misalign_inst", inst, 32'h0);
    cycle(32'h7FFFFFFC, 1'b0, 1'b0, 1'b0);

    fill_line(32'h80000010);
    fill_line(32'h80000020);
    cycle(32'h80000000, 1'b0, 1'b0, 1'b0);
    fill_line(32'h80000000);

    lat = 2; inv_on_rsp = 1'b1;
    fill_line(32'h80000030);

    cycle(32'h80000034, 1'b0, 1'b0, 1'b0);
    cycle(32'h80000038, 1'b1, 1'b1, 1'b0);
    chk("flush_wins", inst, 32'h0);
    cycle(32'h8000003C, 1'b0, 1'b0, 1'b0);
    cycle(32'h80000030, 1'b1, 1'b0, 1'b0);
    chk("stall_hold", inst, rom(32'h8000003C));

    spur = 1'b1; rdy_pct = 60;
    pc = BASE;
    repeat (3000) begin
      lat = $urandom_range(4);
      if ($urandom_range(99) < 65 && !bad(pc + 32'h4)) pc = pc + 32'h4;
      else pc = rnd_addr();
      cycle(pc, $urandom_range(99) < 10, $urandom_range(99) < 5,
            $urandom_range(99) < 3);
    end
    cycle(BASE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
